// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction-timer sequencer.
// Holds the FSM state encoding, default timing values and the LFSR seed/taps.
package reaction_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_TIMING = 3'd2,
        ST_DONE   = 3'd3,
        ST_FAULT  = 3'd4
    } rt_state_t;

    localparam int unsigned RT_TICK_DIV     = 50000;
    localparam int unsigned RT_MIN_DELAY_MS = 1000;
    localparam int unsigned RT_RAND_BITS    = 11;
    localparam logic [13:0] RT_MAX_MS       = 14'd9999;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// Bundle between the button synchronizers, the sequencer and the BCD datapath.
// master: drives go/react, observes results. slave: the sequencer itself.
interface reaction_timer_ctrl_if;
    logic        go;
    logic        react;
    logic        ms_tick;
    logic        cnt_run;
    logic        cnt_clr;
    logic        stim_led;
    logic [13:0] elapsed_ms;
    logic        done;
    logic        false_start;
    logic        timeout;
    logic [13:0] best_ms;

    modport master (
        output go, react,
        input  ms_tick, cnt_run, cnt_clr, stim_led,
        input  elapsed_ms, done, false_start, timeout, best_ms
    );

    modport slave (
        input  go, react,
        output ms_tick, cnt_run, cnt_clr, stim_led,
        output elapsed_ms, done, false_start, timeout, best_ms
    );
endinterface

// File: rtl/rt_lfsr16.sv
// Free-running 16-bit Galois LFSR used to randomise the pre-stimulus delay.
// Ports: clock, reset (sync, active-high, loads seed), out = current state.
module rt_lfsr16
    import reaction_timer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] out
);
    // Non-zero seed and a maximal-length polynomial keep the state off zero.
    always_ff @(posedge clock) begin
        if (reset) out <= LFSR_SEED;
        else       out <= lfsr_next(out);
    end
endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer sequencer: arm on GO, random delay, light LED, time until REACT.
// Ports: clock, reset (sync, active-high), bus (reaction_timer_ctrl_if.slave):
//   go/react in; ms_tick, cnt_run, cnt_clr, stim_led, elapsed_ms, done,
//   false_start, timeout, best_ms out.
// Optional macro RT_BEST_TIME_EN: keeps a best (smallest) valid time in
//   best_ms; when undefined best_ms is tied to zero.
module reaction_timer_ctrl
    import reaction_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV     = RT_TICK_DIV,
    parameter int unsigned MIN_DELAY_MS = RT_MIN_DELAY_MS,
    parameter int unsigned RAND_BITS    = RT_RAND_BITS,
    parameter logic [13:0] MAX_MS       = RT_MAX_MS
) (
    input logic                  clock,
    input logic                  reset,
    reaction_timer_ctrl_if.slave bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    rt_state_t     state;
    logic [PW-1:0] presc;
    logic          tick;
    logic [15:0]   lfsr;
    logic          go_q, react_q;
    logic          go_re, react_re;
    logic [13:0]   delay;
    logic [13:0]   dly_load;
    logic [13:0]   elapsed;
    logic [13:0]   elapsed_nx;
    logic          clr_q, led_q, done_q, fs_q, to_q;
    logic          unused_lfsr;

    rt_lfsr16 u_lfsr (
        .clock (clock),
        .reset (reset),
        .out   (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:RAND_BITS];

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset)     presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + PW'(1);
    end

    assign go_re      = bus.go & ~go_q;
    assign react_re   = bus.react & ~react_q;
    assign dly_load   = 14'(MIN_DELAY_MS) + 14'(lfsr[RAND_BITS-1:0]);
    assign elapsed_nx = elapsed + 14'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            go_q    <= 1'b0;
            react_q <= 1'b0;
            delay   <= '0;
            elapsed <= '0;
            clr_q   <= 1'b0;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
            fs_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            go_q    <= bus.go;
            react_q <= bus.react;
            clr_q   <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE, ST_FAULT: begin
                    if (go_re) begin
                        state   <= ST_ARMED;
                        delay   <= dly_load;
                        elapsed <= '0;
                        clr_q   <= 1'b1;
                        done_q  <= 1'b0;
                        fs_q    <= 1'b0;
                        to_q    <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    // An early press wins over a delay expiring this cycle.
                    if (react_re) begin
                        state <= ST_FAULT;
                        fs_q  <= 1'b1;
                    end else if (tick) begin
                        if (delay == '0) begin
                            state <= ST_TIMING;
                            led_q <= 1'b1;
                        end else begin
                            delay <= delay - 14'd1;
                        end
                    end
                end
                ST_TIMING: begin
                    // A press freezes the count; a coincident tick is dropped.
                    if (react_re) begin
                        state  <= ST_DONE;
                        led_q  <= 1'b0;
                        done_q <= 1'b1;
                    end else if (tick) begin
                        elapsed <= elapsed_nx;
                        if (elapsed_nx >= MAX_MS) begin
                            state  <= ST_DONE;
                            led_q  <= 1'b0;
                            done_q <= 1'b1;
                            to_q   <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ms_tick     = tick;
    assign bus.cnt_run     = led_q & tick;
    assign bus.cnt_clr     = clr_q;
    assign bus.stim_led    = led_q;
    assign bus.elapsed_ms  = elapsed;
    assign bus.done        = done_q;
    assign bus.false_start = fs_q;
    assign bus.timeout     = to_q;

`ifdef RT_BEST_TIME_EN
    logic        new_res;
    logic [13:0] best_q;

    // new_res marks the first DONE cycle of a REACT-terminated trial,
    // so the compare sees the frozen elapsed value.
    always_ff @(posedge clock) begin
        if (reset) begin
            new_res <= 1'b0;
            best_q  <= MAX_MS;
        end else begin
            new_res <= (state == ST_TIMING) && react_re;
            if (new_res && !to_q && (elapsed < best_q))
                best_q <= elapsed;
        end
    end

    assign bus.best_ms = best_q;
`else
    assign bus.best_ms = 14'd0;
`endif

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Randomised self-checking bench for reaction_timer_ctrl.
// Small timing (TICK_DIV=4, MIN_DELAY_MS=2, RAND_BITS=2, MAX_MS=20).
module tb_reaction_timer_ctrl;
    localparam int TD   = 4;
    localparam int MIN  = 2;
    localparam int RB   = 2;
    localparam int MAXV = 20;
    localparam int BND  = 600;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nvec  = 0;
    int   nerr  = 0;
    int   ncyc  = 0;
    int   best_exp = MAXV;

    reaction_timer_ctrl_if bus ();

    reaction_timer_ctrl #(
        .TICK_DIV     (TD),
        .MIN_DELAY_MS (MIN),
        .RAND_BITS    (RB),
        .MAX_MS       (14'(MAXV))
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Non-reset clock edges since the last reset edge.
    always @(posedge clock) begin
        if (reset) ncyc <= 0;
        else       ncyc <= ncyc + 1;
    end

    // Delay chosen when GO is taken after k LFSR advances from the seed.
    function automatic int exp_delay_at(input int k);
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < k; i++) begin
            if (s[0]) s = (s >> 1) ^ 16'hB400;
            else      s = s >> 1;
        end
        return MIN + int'(s) % (1 << RB);
    endfunction

    function automatic int best_now();
`ifdef RT_BEST_TIME_EN
        return best_exp;
`else
        return 0;
`endif
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.go = 1'b0;
        bus.react = 1'b0;
        repeat (3) @(negedge clock);
        best_exp = MAXV;
        nvec++;
        if (bus.stim_led !== 1'b0 || bus.done !== 1'b0 ||
            bus.false_start !== 1'b0 || bus.timeout !== 1'b0 ||
            bus.cnt_clr !== 1'b0 || bus.cnt_run !== 1'b0 ||
            bus.ms_tick !== 1'b0) begin
            nerr++;
            $display("FAIL reset_flags: got %b%b%b%b%b%b%b expected 0000000",
                     bus.stim_led, bus.done, bus.false_start, bus.timeout,
                     bus.cnt_clr, bus.cnt_run, bus.ms_tick);
        end
        nvec++;
        if (bus.elapsed_ms !== 14'd0) begin
            nerr++;
            $display("FAIL reset_elapsed: got %0d expected 0", bus.elapsed_ms);
        end
        nvec++;
        if (bus.best_ms !== 14'(best_now())) begin
            nerr++;
            $display("FAIL reset_best: got %0d expected %0d",
                     bus.best_ms, best_now());
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    // GO (optionally with REACT in the same cycle), then run through ARMED.
    task automatic arm(input bit rgo, input bit gomid);
        int dly, ticks, n;
        bit saw_clr;
        dly = exp_delay_at(ncyc);
        bus.go = 1'b1;
        bus.react = rgo;
        @(negedge clock);
        bus.go = 1'b0;
        bus.react = 1'b0;
        nvec++;
        if (bus.cnt_clr !== 1'b1 || bus.false_start !== 1'b0 ||
            bus.done !== 1'b0 || bus.elapsed_ms !== 14'd0) begin
            nerr++;
            $display("FAIL arm_entry: got clr=%b fs=%b done=%b el=%0d expected 1 0 0 0",
                     bus.cnt_clr, bus.false_start, bus.done, bus.elapsed_ms);
        end
        ticks = 0;
        n = 0;
        saw_clr = 1'b0;
        while (!bus.stim_led && n < BND) begin
            if (bus.ms_tick) ticks++;
            bus.go = (gomid && n == 1);
            @(negedge clock);
            n++;
            if (bus.cnt_clr) saw_clr = 1'b1;
        end
        bus.go = 1'b0;
        nvec++;
        if (bus.stim_led !== 1'b1 || ticks != dly + 1 || saw_clr) begin
            nerr++;
            $display("FAIL arm_delay: got led=%b ticks=%0d clr=%b expected 1 %0d 0",
                     bus.stim_led, ticks, saw_clr, dly + 1);
        end
    endtask

    task automatic trial(input int rms, input bit on_tick,
                         input bit rgo, input bit gomid);
        int t, n, bad;
        arm(rgo, gomid);
        t = 0;
        n = 0;
        bad = 0;
        while (n < BND) begin
            if (bus.elapsed_ms !== 14'(t)) bad++;
            if (bus.cnt_run !== bus.ms_tick) bad++;
            if (t == rms && bus.ms_tick == on_tick) break;
            if (bus.ms_tick) t++;
            @(negedge clock);
            n++;
        end
        bus.react = 1'b1;
        @(negedge clock);
        bus.react = 1'b0;
        nvec++;
        if (bad != 0 || n >= BND) begin
            nerr++;
            $display("FAIL timing_run: got %0d bad samples expected 0", bad);
        end
        nvec++;
        if (bus.done !== 1'b1 || bus.stim_led !== 1'b0 ||
            bus.timeout !== 1'b0 || bus.cnt_run !== 1'b0 ||
            bus.elapsed_ms !== 14'(rms)) begin
            nerr++;
            $display("FAIL react_result: got done=%b led=%b to=%b run=%b el=%0d expected 1 0 0 0 %0d",
                     bus.done, bus.stim_led, bus.timeout, bus.cnt_run,
                     bus.elapsed_ms, rms);
        end
        if (rms < best_exp) best_exp = rms;
        @(negedge clock);
        nvec++;
        if (bus.best_ms !== 14'(best_now())) begin
            nerr++;
            $display("FAIL best_ms: got %0d expected %0d", bus.best_ms, best_now());
        end
    endtask

    task automatic test_false_start(input bit at_expiry);
        int dly, ticks, n, cyc;
        bit led_seen;
        dly = exp_delay_at(ncyc);
        cyc = $urandom_range(0, 4);
        bus.go = 1'b1;
        @(negedge clock);
        bus.go = 1'b0;
        ticks = 0;
        n = 0;
        led_seen = 1'b0;
        while (n < BND) begin
            if (bus.stim_led) led_seen = 1'b1;
            if (at_expiry && ticks == dly && bus.ms_tick) break;
            if (!at_expiry && n == cyc) break;
            if (bus.ms_tick) ticks++;
            @(negedge clock);
            n++;
        end
        bus.react = 1'b1;
        @(negedge clock);
        bus.react = 1'b0;
        nvec++;
        if (bus.false_start !== 1'b1 || bus.stim_led !== 1'b0 ||
            bus.cnt_run !== 1'b0 || bus.done !== 1'b0 ||
            bus.elapsed_ms !== 14'd0 || led_seen || n >= BND) begin
            nerr++;
            $display("FAIL false_start: got fs=%b led=%b run=%b done=%b el=%0d seen=%b expected 1 0 0 0 0 0",
                     bus.false_start, bus.stim_led, bus.cnt_run, bus.done,
                     bus.elapsed_ms, led_seen);
        end
        led_seen = 1'b0;
        repeat (4 * TD * (MIN + 4)) begin
            @(negedge clock);
            if (bus.stim_led || bus.cnt_run || !bus.false_start)
                led_seen = 1'b1;
        end
        nvec++;
        if (led_seen) begin
            nerr++;
            $display("FAIL fault_hold: got led/run/fs change=1 expected 0");
        end
    endtask

    task automatic test_timeout();
        int t, n;
        bit over;
        arm(1'b0, 1'b0);
        t = 0;
        n = 0;
        over = 1'b0;
        while (!bus.done && n < BND) begin
            if (bus.elapsed_ms > 14'(MAXV)) over = 1'b1;
            if (bus.ms_tick) t++;
            @(negedge clock);
            n++;
        end
        nvec++;
        if (bus.done !== 1'b1 || bus.timeout !== 1'b1 ||
            bus.elapsed_ms !== 14'(MAXV) || t != MAXV || over ||
            bus.stim_led !== 1'b0) begin
            nerr++;
            $display("FAIL timeout: got done=%b to=%b el=%0d ticks=%0d led=%b expected 1 1 %0d %0d 0",
                     bus.done, bus.timeout, bus.elapsed_ms, t, bus.stim_led,
                     MAXV, MAXV);
        end
        repeat (3 * TD) @(negedge clock);
        nvec++;
        if (bus.elapsed_ms !== 14'(MAXV) || bus.best_ms !== 14'(best_now())) begin
            nerr++;
            $display("FAIL timeout_hold: got el=%0d best=%0d expected %0d %0d",
                     bus.elapsed_ms, bus.best_ms, MAXV, best_now());
        end
    endtask

    task automatic test_best_sequence();
        test_reset();
        trial(7, 1'b0, 1'b0, 1'b0);
        trial(3, 1'b0, 1'b0, 1'b0);
        trial(9, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_go_react_same();
        trial(6, 1'b0, 1'b1, 1'b0);
        test_reset();
        trial(4, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        repeat (14) begin
            repeat ($urandom_range(0, 6)) @(negedge clock);
            if ($urandom_range(0, 3) == 0)
                test_false_start($urandom_range(0, 1) == 1);
            else
                trial($urandom_range(1, MAXV - 1), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
    endtask

    task automatic test_reset_mid_timing();
        bit saw;
        arm(1'b0, 1'b0);
        repeat (6) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        best_exp = MAXV;
        nvec++;
        if (bus.stim_led !== 1'b0 || bus.cnt_run !== 1'b0 ||
            bus.cnt_clr !== 1'b0 || bus.done !== 1'b0 ||
            bus.elapsed_ms !== 14'd0 || bus.best_ms !== 14'(best_now())) begin
            nerr++;
            $display("FAIL reset_mid: got led=%b run=%b clr=%b done=%b el=%0d best=%0d expected 0 0 0 0 0 %0d",
                     bus.stim_led, bus.cnt_run, bus.cnt_clr, bus.done,
                     bus.elapsed_ms, bus.best_ms, best_now());
        end
        reset = 1'b0;
        saw = 1'b0;
        repeat (4 * TD) begin
            @(negedge clock);
            if (bus.cnt_clr || bus.stim_led || bus.done) saw = 1'b1;
        end
        nvec++;
        if (saw) begin
            nerr++;
            $display("FAIL reset_idle: got activity=1 expected 0");
        end
    endtask

    initial begin
        bus.go = 1'b0;
        bus.react = 1'b0;
        test_reset();
        trial(5, 1'b0, 1'b0, 1'b0);
        test_false_start(1'b0);
        test_false_start(1'b1);
        test_timeout();
        test_best_sequence();
        trial(4, 1'b1, 1'b0, 1'b0);
        test_go_react_same();
        test_random();
        test_reset_mid_timing();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
